// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// codes, memory depth default and instruction width.
package imem_loader_pkg;

  localparam int IMEM_DEPTH_DEF = 256;
  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = INSTR_W / 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_HDR_LO = 3'd0;
  localparam state_t ST_HDR_HI = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_ERR    = 3'd4;

  // The loader takes bytes only while it is still parsing the image.
  function automatic logic is_loading(input state_t s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is a
// one-cycle pulse in the cycle after the fourth byte is accepted.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic [1:0]         byte_cnt,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word_data
);

  logic [1:0]         cnt_q,   cnt_d;
  logic [INSTR_W-1:0] shift_q, shift_d;
  logic [INSTR_W-1:0] word_q,  word_d;
  logic               valid_q, valid_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (byte_valid) begin
      // Shift in from the top so the first byte ends up in bits [7:0].
      shift_d = {byte_data, shift_q[INSTR_W-1:8]};
      cnt_d   = cnt_q + 2'd1;
      if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        word_d  = shift_d;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign word_valid = valid_q;
  assign word_data  = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte image, writes it into
// instruction memory and releases the cpu from reset once it is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int AW         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [AW-1:0]      imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  state_t        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [AW:0]   idx_q,   idx_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic          done_q,  done_d;
  logic          err_q,   err_d;
  logic          cpu_rst_q, cpu_rst_d;

  logic          accept;
  logic          asm_valid;
  logic [1:0]    asm_cnt;
  logic          word_valid;
  logic [15:0]   hdr_n;
  logic          last_write;

  assign in_ready  = !rst && is_loading(state_q);
  assign accept    = in_valid && in_ready;
  assign asm_valid = accept && (state_q == ST_DATA);
  assign hdr_n     = {in_data, count_q[7:0]};

  // idx_q already points past the word being written, so it equals N on
  // the final write.
  assign last_write = word_valid && (32'(idx_q) == 32'(count_q));

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (asm_valid),
    .byte_data  (in_data),
    .byte_cnt   (asm_cnt),
    .word_valid (word_valid),
    .word_data  (imem_wdata)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    case (state_q)
      ST_HDR_LO: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (accept) begin
          count_d[15:8] = in_data;
          if (hdr_n == 16'd0) begin
            state_d = ST_DONE;
          end else if ({16'd0, hdr_n} > 32'(IMEM_DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // Address is captured together with the word so both hold steady
        // after the write pulse.
        if (asm_valid && (asm_cnt == 2'(BYTES_PER_WORD - 1))) begin
          addr_d = idx_q[AW-1:0];
          idx_d  = idx_q + 1'b1;
        end
        if (last_write) begin
          state_d = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    done_d    = done_q    || (state_d == ST_DONE);
    err_d     = err_q     || (state_d == ST_ERR);
    cpu_rst_d = cpu_rst_q && (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HDR_LO;
      count_q   <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign imem_we   = word_valid;
  assign imem_addr = addr_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed image scenarios plus
// randomized images and stalls, checked against a queue-based write model.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  imem_loader #(.IMEM_DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          wr_count = 0;
  wr_t         exp_q[$];
  logic [31:0] mem [DEPTH];
  logic [31:0] img [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Every observed write must be the next one the model expects.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_count++;
      mem[imem_addr] = imem_wdata;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'd0, imem_wdata}, 64'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) sync();
  endtask

  // Hold the byte until the loader takes it; returns #1 after that edge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 0; b < 4; b++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(w[8*b +: 8]);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    sync();
    sync();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  task automatic check_image(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== img[i]) bad++;
    check({tag, "_image"}, 64'(bad), 64'd0);
  endtask

  // Full load of img[0..n-1] with 1 <= n <= DEPTH.
  task automatic load_image(input string tag, input int n, input int max_gap);
    logic [15:0] hdr;
    int          w0;
    hdr = 16'(n);
    w0  = wr_count;
    send_byte(hdr[7:0]);
    send_byte(hdr[15:8]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: 8'(i), data: img[i]});
      send_word(img[i], max_gap);
    end
    wait_done(tag);
    check({tag, "_wr_count"}, 64'(wr_count - w0), 64'(n));
    check_image(tag, n);
  endtask

  task automatic offer_after_end(input string tag, input int n);
    int w0;
    w0       = wr_count;
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      check({tag, "_no_ready"}, 64'(in_ready), 64'd0);
      sync();
    end
    in_valid = 1'b0;
    check({tag, "_no_writes"}, 64'(wr_count - w0), 64'd0);
  endtask

  logic [31:0] prog [8] = '{32'h00500093, 32'h00300113, 32'h00000193, 32'h001101B3,
                            32'h00800213, 32'h00418663, 32'h00100513, 32'h00000513};

  initial begin
    int c0;
    int n;

    // Reset values, then in_ready rising once rst drops.
    rst = 1'b1;
    sync();
    @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_done_err", {done, err}, 64'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);
    sync();

    // Eight-word program streamed back to back.
    for (int i = 0; i < 8; i++) begin
      img[i] = prog[i];
      exp_q.push_back('{addr: 8'(i), data: prog[i]});
    end
    c0 = cyc;
    send_byte(8'h08);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_word(prog[i], 0);
    check("b2b_cycles", 64'(cyc - c0), 64'd34);
    @(negedge clk);
    check("last_we", 64'(imem_we), 64'd1);
    check("last_addr", 64'(imem_addr), 64'd7);
    check("done_not_yet", 64'(done), 64'd0);
    @(negedge clk);
    check("prog_done", 64'(done), 64'd1);
    check("prog_cpu_rst", 64'(cpu_rst), 64'd0);
    check("prog_we_low", 64'(imem_we), 64'd0);
    check("addr_held", 64'(imem_addr), 64'd7);
    check("wdata_held", 64'(imem_wdata), 64'(prog[7]));
    check("prog_pending", 64'(exp_q.size()), 64'd0);
    check_image("prog", 8);
    sync();
    offer_after_end("after_done", 4);
    check("done_sticky", 64'(done), 64'd1);

    // Zero-length image.
    do_reset();
    n = wr_count;
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("n0_done", 64'(done), 64'd1);
    check("n0_ready", 64'(in_ready), 64'd0);
    check("n0_writes", 64'(wr_count - n), 64'd0);
    sync();

    // Oversize header: 257 words into a 256-word memory.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    check("n257_err", 64'(err), 64'd1);
    check("n257_cpu_rst", 64'(cpu_rst), 64'd1);
    check("n257_done", 64'(done), 64'd0);
    sync();
    offer_after_end("n257", 6);
    check("n257_err_sticky", 64'(err), 64'd1);

    // N=1 with in_valid toggling every cycle.
    do_reset();
    img[0] = 32'h00500093;
    n = wr_count;
    send_byte(8'h01);
    idle(1);
    send_byte(8'h00);
    for (int b = 0; b < 3; b++) begin
      idle(1);
      send_byte(img[0][8*b +: 8]);
    end
    idle(1);
    check("n1_no_early_write", 64'(wr_count - n), 64'd0);
    exp_q.push_back('{addr: 8'd0, data: img[0]});
    send_byte(8'h00);
    wait_done("n1");
    check("n1_one_write", 64'(wr_count - n), 64'd1);
    check("n1_mem0", 64'(mem[0]), 64'h00500093);

    // Abort after two bytes of word 3, then a clean restream.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      img[i] = $urandom;
      mem[i] = 32'hBAD0_0000 | 32'(i);
    end
    send_byte(8'h08);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{addr: 8'(i), data: img[i]});
      send_word(img[i], 0);
    end
    send_byte(img[3][7:0]);
    send_byte(img[3][15:8]);
    check("abort_pending", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    sync();
    @(negedge clk);
    check("abort_no_we", 64'(imem_we), 64'd0);
    check("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    rst = 1'b0;
    sync();
    load_image("restream", 8, 2);

    // Randomized images with random stalls, including the full-depth edge.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = (t == 5) ? DEPTH : int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      load_image("rand", n, (t == 5) ? 0 : 3);
    end

    // Random oversize headers.
    for (int t = 0; t < 3; t++) begin
      logic [15:0] h;
      do_reset();
      h = 16'($urandom_range(DEPTH + 1, 65535));
      send_byte(h[7:0]);
      send_byte(h[15:8]);
      @(negedge clk);
      check("rand_err", {err, done, cpu_rst}, 64'b101);
      sync();
      offer_after_end("rand_err", 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 256, meaning instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter AW, default 8, meaning word-address width, where 2**AW >= IMEM_DEPTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream byte-stream data valid.
REQ-006 The block SHALL have port in_data, input, 8 bits: upstream byte.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the loader accepts a byte when in_valid and in_ready are both high on a clk edge.
REQ-008 The block SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, AW bits: instruction-memory word address.
REQ-010 The block SHALL have port imem_wdata, output, 32 bits: instruction word to write.
REQ-011 The block SHALL have port cpu_rst, output, 1 bit: holds the cpu (PC and pipeline-free core) in reset while high.
REQ-012 The block SHALL have port done, output, 1 bit: the image loaded successfully (sticky).
REQ-013 The block SHALL have port err, output, 1 bit: the header word count exceeded IMEM_DEPTH (sticky).

Function
REQ-014 The image format SHALL be a 16-bit word count N, sent as 2 bytes little-endian, followed by N words of 4 bytes each, little-endian.
REQ-015 The FSM SHALL have states HDR_LO, HDR_HI, DATA, DONE, ERR, with reset state HDR_LO.
REQ-016 in_ready SHALL be high in HDR_LO, HDR_HI and DATA, and low in DONE and ERR.
REQ-017 HDR_LO SHALL go to HDR_HI on an accepted byte, latching count[7:0].
REQ-018 On an accepted byte in HDR_HI, the FSM SHALL latch count[15:8] and then:
- go to DONE if N==0;
- go to ERR if N>IMEM_DEPTH;
- otherwise go to DATA.
REQ-019 In DATA, a byte counter (0..3) SHALL shift accepted bytes into a word assembly register, with byte 0 in bits [7:0].
REQ-020 On acceptance of byte 3, the block SHALL register the assembled word, and the next cycle SHALL present exactly one imem_we=1 pulse with imem_addr = word index and imem_wdata = word.
REQ-021 The word index SHALL start at 0, increment by 1 after each write, and never wrap: N <= IMEM_DEPTH guarantees the last index is N-1.
REQ-022 In the cycle the write of word N-1 is presented, the FSM SHALL move to DONE; done goes to 1 and cpu_rst goes to 0 on the following edge.
REQ-023 A cycle with in_valid low SHALL stall the FSM with no state change, and partial word bytes SHALL be retained.
REQ-024 Back-to-back bytes every cycle SHALL be accepted with no bubbles, giving sustained throughput of 1 word per 4 cycles.
REQ-025 imem_we SHALL be 0 in every cycle except the write pulses.
REQ-026 imem_addr and imem_wdata are don't-care when imem_we=0, but SHALL hold their last value.
REQ-027 DONE and ERR SHALL be terminal until rst; bytes offered there SHALL not be accepted.
REQ-028 In ERR, cpu_rst SHALL stay 1, err=1, done=0, and no memory write SHALL occur.

Reset
REQ-029 While rst=1, the block SHALL set: state=HDR_LO, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, and byte counter, word index and count all 0.
REQ-030 rst asserted mid-load SHALL abort immediately; no write pulse SHALL appear in the cycle after the reset edge, and a fresh header is expected.
REQ-031 in_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the default IMEM_DEPTH, and the 32-bit instruction width constant, also used by instr_memory.
REQ-033 The byte-to-word assembler (byte counter plus shift register, emitting a word_valid pulse) SHALL be one sub-module, word_assembler; the FSM and address counter remain in imem_loader.
REQ-034 The system top SHALL connect imem_loader to the instruction memory write port and drive the cpu reset from cpu_rst, replacing preloaded memory contents.

Verification
REQ-035 Stream 08 00, then 8 words (00500093, 00300113, 00000193, 001101B3, 00800213, 00418663, 00100513, 00000513) at 1 byte/cycle -> 8 imem_we pulses, addr 0..7, data as listed; done=1 and cpu_rst=0 one cycle after the addr-7 write.
REQ-036 Header 00 00 -> done=1 after the second byte, zero writes, in_ready=0 thereafter.
REQ-037 Header 01 01 (N=257, IMEM_DEPTH=256) -> err=1, cpu_rst stays 1, no writes, further bytes not accepted.
REQ-038 N=1 with in_valid toggling 1/0 each cycle -> a single write at addr 0 with data 0x00500093 (bytes 93 00 50 00), and no write before the 4th byte.
REQ-039 rst pulsed after 2 bytes of word 3 of an 8-word load, then a full restream -> writes restart at addr 0 and final memory matches the image.
REQ-040 Bytes offered after done -> in_ready=0, no writes, done stays 1.
